// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter feeding one registered output slot.
// Grants are combinational; the winning word is captured on the same edge.
module mux2_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             sel,
  output logic [7:0]       xfer_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_A = 2'd1,
    HOLD_B = 2'd2
  } state_t;

  state_t           state_p1;
  state_t           state_nxt;
  logic             load;
  logic             win_b;
  logic             grant;
  logic             prio_b_p1;
  logic [WIDTH-1:0] data_p1;
  logic             sel_p1;
  logic [7:0]       cnt_p1;

  // Arbitration and next-state decode
  always_comb begin
    state_nxt = state_p1;
    load      = (state_p1 == IDLE) || out_ready;
    // B wins when it is the only requester, or when both ask and B is owed the turn.
    win_b     = req_b && (!req_a || prio_b_p1);
    grant     = !rst && load && (req_a || req_b);
    gnt_a     = grant && !win_b;
    gnt_b     = grant && win_b;
    if (load) begin
      if (req_a || req_b) begin
        state_nxt = win_b ? HOLD_B : HOLD_A;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  // Output slot register; data and select persist after the slot empties
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1  <= IDLE;
      prio_b_p1 <= 1'b0;
      data_p1   <= '0;
      sel_p1    <= 1'b0;
      cnt_p1    <= 8'd0;
    end else begin
      state_p1 <= state_nxt;
      if (grant) begin
        data_p1   <= win_b ? data_b : data_a;
        sel_p1    <= win_b;
        prio_b_p1 <= !win_b;
      end
      if ((state_p1 != IDLE) && out_ready) begin
        cnt_p1 <= cnt_p1 + 8'd1;
      end
    end
  end

  assign out_valid  = (state_p1 != IDLE);
  assign out_data   = data_p1;
  assign sel        = sel_p1;
  assign xfer_count = cnt_p1;

endmodule

// File: doc/mux2_rr_arbiter.md
MUX2_RR_ARBITER -- requirements
Module: mux2_rr_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, data width of each requester and of the output.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: req_a  input  1  requester A has a word on data_a.
REQ-005 Port: data_a  input  WIDTH  requester A word; held stable while req_a=1 and gnt_a=0.
REQ-006 Port: req_b  input  1  requester B has a word on data_b.
REQ-007 Port: data_b  input  WIDTH  requester B word; held stable while req_b=1 and gnt_b=0.
REQ-008 Port: gnt_a  output  1  combinational; A's word is captured at this clock edge.
REQ-009 Port: gnt_b  output  1  combinational; B's word is captured at this clock edge.
REQ-010 Port: out_valid  output  1  out_data holds an unconsumed word.
REQ-011 Port: out_ready  input  1  downstream accepts out_data when out_valid=1.
REQ-012 Port: out_data  output  WIDTH  registered mux output.
REQ-013 Port: sel  output  1  registered select of the word in out_data, 0=A, 1=B.
REQ-014 Port: xfer_count  output  8  count of completed output transfers.

Function
REQ-015 The block SHALL share one 2:1 mux path between requesters A and B through a single-entry registered output stage.
REQ-016 FSM states SHALL be IDLE (output empty), HOLD_A (holding A's word) and HOLD_B (holding B's word).
REQ-017 load = (state==IDLE) or (out_ready=1), evaluated each cycle.
REQ-018 On load with at least one request, the winner SHALL be selected, its data captured into out_data, sel set to the winner, and the next state set to HOLD_A or HOLD_B.
REQ-019 On load with no request, the next state SHALL be IDLE and out_valid SHALL fall; out_data and sel SHALL keep their last values.
REQ-020 If not load, all registers SHALL hold, and gnt_a and gnt_b SHALL be 0.
REQ-021 gnt_a = load and A wins; gnt_b = load and B wins; gnt_a and gnt_b SHALL never both be 1.
REQ-022 Single request: the requester that is asserting SHALL win.
REQ-023 Both requesting: the winner SHALL be the requester not granted most recently; a priority flag SHALL update only on a grant.
REQ-024 out_valid SHALL be 1 exactly in HOLD_A and HOLD_B.
REQ-025 Latency: a word granted at edge N SHALL appear on out_data with out_valid=1 after edge N, with zero bubble cycles.
REQ-026 Back-to-back: with out_ready=1 held, a new word SHALL be captured every cycle while any request is present.
REQ-027 xfer_count SHALL increment by 1 on each edge where out_valid=1 and out_ready=1.
REQ-028 xfer_count SHALL wrap from 255 to 0.
REQ-029 out_ready while out_valid=0 SHALL have no effect on xfer_count.
REQ-030 A request deasserted before its grant SHALL be dropped without a grant.
REQ-031 Handshake-consume and new grant in the same cycle SHALL both take effect: the count increments and out_data is replaced.

Reset
REQ-032 rst=1 at a rising edge SHALL force state=IDLE, out_valid=0, out_data=0, sel=0, xfer_count=0, and priority to A.
REQ-033 While rst=1, gnt_a and gnt_b SHALL be 0.
REQ-034 Reset asserted mid-transfer SHALL discard the held word, and no transfer SHALL be counted in that cycle.
REQ-035 Reset SHALL take effect only on a clock edge, with no asynchronous path.

Verification
REQ-036 Reset: hold rst=1 for 2 cycles with random inputs -> out_valid=0, out_data=0, sel=0, xfer_count=0, gnt_a=gnt_b=0.
REQ-037 Single requester: req_a=1, data_a=8'h3C, out_ready=0 -> gnt_a pulses 1 cycle, then out_data=8'h3C, sel=0, out_valid=1 stays high; then out_ready=1 for 1 cycle -> xfer_count=1.
REQ-038 Contention: req_a=req_b=1 (data 8'hA1 and 8'hB2), out_ready=1 for 4 cycles -> out_data sequence A1, B2, A1, B2; sel sequence 0, 1, 0, 1; gnt signals alternate.
REQ-039 Backpressure: both requesting, out_ready=0 for 5 cycles -> no grants and out_data stable; out_ready=1 -> the next grant goes to the other requester.
REQ-040 Wrap: 256 transfers -> xfer_count returns to 0; one more transfer -> xfer_count=1.
REQ-041 Reset mid-operation: rst=1 while in HOLD_B with out_ready=1 -> next cycle out_valid=0 and xfer_count=0; with both requesting afterwards, A is granted first.
